// File: rtl/alu_seq.sv
// Handshaked MIPS-funct ALU with a registered result stage.
// MULTU (shift-add) and DIVU (restoring) iterate one bit per clock.
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter bit HOLD_FLAGS = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [5:0]       i_aluc,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_r,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_negative,
    output logic             o_overflow,
    output logic             o_flag
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;
    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_SLLV  = 6'b000100;
    localparam logic [5:0] OP_SRLV  = 6'b000110;
    localparam logic [5:0] OP_SRAV  = 6'b000111;
    localparam logic [5:0] OP_JR    = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_opa;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_sh;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_res;
    logic [WIDTH-1:0]  r_hi;
    logic              r_zero;
    logic              r_carry;
    logic              r_neg;
    logic              r_ovf;
    logic              r_flag;

    logic              w_accept;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_multi;
    logic [SW-1:0]     w_shamt;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_diff;
    logic [WIDTH-1:0]  w_sra;
    logic              w_slt;
    logic [WIDTH-1:0]  w_res;
    logic [WIDTH-1:0]  w_hi;
    logic              w_carry;
    logic              w_ovf;
    logic              w_flag;
    logic [WIDTH:0]    w_mul_sum;
    logic [WIDTH:0]    w_div_sh;
    logic              w_div_ge;
    logic [WIDTH-1:0]  w_div_sub;

    assign o_in_ready  = (r_state == S_IDLE) && (!r_out_valid || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_is_mul    = (i_aluc == OP_MULTU);
    assign w_is_div    = (i_aluc == OP_DIVU) && (i_b != {WIDTH{1'b0}});
    assign w_multi     = w_is_mul || w_is_div;

    assign w_shamt     = i_a[SW-1:0];
    assign w_sum       = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff      = {1'b0, i_a} - {1'b0, i_b};
    assign w_sra       = $signed(i_b) >>> w_shamt;
    assign w_slt       = ($signed(i_a) < $signed(i_b));

    // Divide-by-zero never iterates, so the DIVU arm only ever serves b==0.
    assign w_mul_sum   = r_sh[0] ? ({1'b0, r_acc} + {1'b0, r_opa}) : {1'b0, r_acc};
    assign w_div_sh    = {r_acc, r_sh[WIDTH-1]};
    assign w_div_ge    = (w_div_sh >= {1'b0, r_opa});
    assign w_div_sub   = w_div_sh[WIDTH-1:0] - r_opa;

    // Single-cycle result and flag computation from the live operands.
    always_comb begin
        w_res   = {WIDTH{1'b0}};
        w_hi    = {WIDTH{1'b0}};
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_flag  = 1'b0;
        case (i_aluc)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_ADDU: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUBU: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_AND:           w_res = i_a & i_b;
            OP_OR:            w_res = i_a | i_b;
            OP_XOR:           w_res = i_a ^ i_b;
            OP_NOR:           w_res = ~(i_a | i_b);
            OP_SLT: begin
                w_res  = {{(WIDTH-1){1'b0}}, w_slt};
                w_flag = w_slt;
            end
            OP_SLTU: begin
                w_res  = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
                w_flag = w_diff[WIDTH];
            end
            OP_SLL, OP_SLLV:  w_res = i_b << w_shamt;
            OP_SRL, OP_SRLV:  w_res = i_b >> w_shamt;
            OP_SRA, OP_SRAV:  w_res = w_sra;
            OP_JR:            w_res = i_a;
            OP_LUI:           w_res = i_a << (WIDTH / 2);
            OP_DIVU: begin
                w_res  = {WIDTH{1'b1}};
                w_hi   = i_a;
                w_flag = 1'b1;
            end
            default:          w_res = {WIDTH{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end else if (w_accept && w_is_div) begin
                    w_state_nxt = S_DIV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Iteration datapath: {r_acc,r_sh} is the product pair or remainder/quotient pair.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {SW{1'b0}};
            r_opa <= {WIDTH{1'b0}};
            r_acc <= {WIDTH{1'b0}};
            r_sh  <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_multi) begin
                        r_cnt <= {SW{1'b0}};
                        r_acc <= {WIDTH{1'b0}};
                        r_opa <= w_is_mul ? i_a : i_b;
                        r_sh  <= w_is_mul ? i_b : i_a;
                    end
                end
                S_MUL: begin
                    {r_acc, r_sh} <= {w_mul_sum, r_sh[WIDTH-1:1]};
                    r_cnt         <= r_cnt + CNT_ONE;
                end
                S_DIV: begin
                    r_acc <= w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
                    r_sh  <= {r_sh[WIDTH-2:0], w_div_ge};
                    r_cnt <= r_cnt + CNT_ONE;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Output stage: load on single-cycle accept or iteration done, clear on transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_res       <= {WIDTH{1'b0}};
            r_hi        <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_flag      <= 1'b0;
        end else if (w_accept && !w_multi) begin
            r_out_valid <= 1'b1;
            r_res       <= w_res;
            r_hi        <= w_hi;
            r_zero      <= (w_res == {WIDTH{1'b0}});
            r_carry     <= w_carry;
            r_neg       <= w_res[WIDTH-1];
            r_ovf       <= w_ovf;
            r_flag      <= w_flag;
        end else if (r_state == S_DONE) begin
            r_out_valid <= 1'b1;
            r_res       <= r_sh;
            r_hi        <= r_acc;
            r_zero      <= (r_sh == {WIDTH{1'b0}});
            r_carry     <= 1'b0;
            r_neg       <= r_sh[WIDTH-1];
            r_ovf       <= 1'b0;
            r_flag      <= 1'b0;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_r         = r_res;
    assign o_hi        = r_hi;
    assign o_zero      = r_zero  & (HOLD_FLAGS | r_out_valid);
    assign o_carry     = r_carry & (HOLD_FLAGS | r_out_valid);
    assign o_negative  = r_neg   & (HOLD_FLAGS | r_out_valid);
    assign o_overflow  = r_ovf   & (HOLD_FLAGS | r_out_valid);
    assign o_flag      = r_flag  & (HOLD_FLAGS | r_out_valid);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed scenarios plus random ops checked
// against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [5:0]    aluc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  r;
    logic [W-1:0]  hi;
    logic          zero, carry, negative, overflow, flag;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .HOLD_FLAGS(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .i_aluc(aluc), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_r(r), .o_hi(hi), .o_zero(zero), .o_carry(carry), .o_negative(negative),
        .o_overflow(overflow), .o_flag(flag)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] r;
        logic [31:0] hi;
        logic [4:0]  f;   // {zero, carry, negative, overflow, flag}
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;
    logic [5:0] seq1 [17];
    logic [5:0] ops  [20];

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [5:0] op);
        exp_t e;
        longint s;
        logic [63:0] u;
        int unsigned sh;
        logic [31:0] res, h;
        logic c, v, f;
        res = 32'd0; h = 32'd0; c = 1'b0; v = 1'b0; f = 1'b0; u = 64'd0; s = 0;
        sh = ma % 32;
        case (op)
            6'h20: begin res = ma + mb; s = longint'($signed(ma)) + longint'($signed(mb));
                         v = (s != longint'($signed(res))); end
            6'h21: begin u = 64'(ma) + 64'(mb); res = u[31:0]; c = u[32]; end
            6'h22: begin res = ma - mb; s = longint'($signed(ma)) - longint'($signed(mb));
                         v = (s != longint'($signed(res))); end
            6'h23: begin res = ma - mb; c = (ma < mb); end
            6'h24: res = ma & mb;
            6'h25: res = ma | mb;
            6'h26: res = ma ^ mb;
            6'h27: res = ~(ma | mb);
            6'h2a: begin f = ($signed(ma) < $signed(mb)); res = {31'd0, f}; end
            6'h2b: begin f = (ma < mb); res = {31'd0, f}; end
            6'h00, 6'h04: res = mb << sh;
            6'h02, 6'h06: res = mb >> sh;
            6'h03, 6'h07: res = mb[31] ? ~((~mb) >> sh) : (mb >> sh);
            6'h08: res = ma;
            6'h0f: res = ma * 32'd65536;
            6'h19: begin u = 64'(ma) * 64'(mb); res = u[31:0]; h = u[63:32]; end
            6'h1b: begin
                if (mb == 32'd0) begin res = 32'hffffffff; h = ma; f = 1'b1; end
                else begin res = ma / mb; h = ma % mb; end
            end
            default: res = 32'd0;
        endcase
        e.op = op; e.r = res; e.hi = h;
        e.f = {(res == 32'd0), c, res[31], v, f};
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hffffffff;
            2:       return 32'h80000000;
            3:       return 32'h7fffffff;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [5:0] op);
        int w = 0;
        bit ok = 1'b0;
        a = ia; b = ib; aluc = op; in_valid = 1'b1;
        while (!ok && w < 400) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else w++;
        end
        @(posedge clk);
        if (ok) q.push_back(model(ia, ib, op));
        else begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", w);
        end
        #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; aluc = 6'($urandom);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every transfer is checked against the oldest expected result.
    initial begin
        exp_t e, act;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result: got r=%h hi=%h, expected no result", r, hi);
                end else begin
                    e = q.pop_front();
                    act.op = e.op; act.r = r; act.hi = hi;
                    act.f = {zero, carry, negative, overflow, flag};
                    n_cmp++;
                    if (act !== e) begin
                        n_bad++;
                        $display("FAIL result op=%h: got r=%h hi=%h zcnvf=%b, expected r=%h hi=%h zcnvf=%b",
                                 e.op, act.r, act.hi, act.f, e.r, e.hi, e.f);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, cnt, w;
        exp_t es;
        seq1 = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0f};
        ops  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h0f, 6'h19, 6'h1b};
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; aluc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_r_hi", {r, hi}, 64'd0);
        check("reset_flags", 64'({zero, carry, negative, overflow, flag}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        t0 = cyc;
        foreach (seq1[i]) issue(32'h1c, 32'h21, seq1[i]);
        check("back_to_back_cycles", 64'(cyc - t0), 64'd17);

        issue(32'h7fffffff, 32'd1, 6'h20);
        issue(32'hffffffff, 32'hffffffff, 6'h21);

        issue(32'hffffffff, 32'd2, 6'h19);
        cnt = 0;
        repeat (33) begin @(negedge clk); if (!in_ready && !out_valid) cnt++; end
        check("multu_busy_cycles", 64'(cnt), 64'd33);
        @(negedge clk);
        check("multu_valid_at_33", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        issue(32'd100, 32'd7, 6'h1b);
        cnt = 0;
        repeat (33) begin @(negedge clk); if (!in_ready && !out_valid) cnt++; end
        check("divu_busy_cycles", 64'(cnt), 64'd33);
        @(negedge clk);
        check("divu_valid_at_33", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        issue(32'd5, 32'd0, 6'h1b);
        @(negedge clk);
        check("divz_valid_next_clk", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        out_ready = 1'b0;
        es = model(32'd3, 32'd9, 6'h22);
        issue(32'd3, 32'd9, 6'h22);
        a = 32'd10; b = 32'd20; aluc = 6'h20; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_r", 64'(r), 64'(es.r));
            check("stall_flags", 64'({zero, carry, negative, overflow, flag}), 64'(es.f));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        q.push_back(model(32'd10, 32'd20, 6'h20));
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        issue(32'h12345678, 32'h9abcdef0, 6'h19);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_r_hi", {r, hi}, 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        issue(32'd5, 32'd6, 6'h20);

        rand_rdy = 1'b1;
        repeat (300) begin
            logic [5:0] op;
            int k;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            k = $urandom_range(0, 27);
            op = (k < 20) ? ops[k] : 6'($urandom);
            issue(rnd_val(), rnd_val(), op);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        w = 0;
        while (q.size() != 0 && w < 2000) begin @(posedge clk); w++; end
        check("drain_queue_empty", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
